// File: rtl/ctr_pkg.sv
// Shared definitions for the programmable counter: overflow-mode encodings
// and the one-shot run-state type.
package ctr_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   // 2'b11 is reserved and decodes as wrap.

   typedef enum logic [1:0] {
      OS_IDLE = 2'd0,
      OS_RUN  = 2'd1,
      OS_DONE = 2'd2
   } os_state_t;

endpackage

// File: rtl/prog_counter.sv
// Loadable up/down counter with a run-time terminal value and wrap,
// saturate and one-shot overflow modes. Outputs are all registered.
module prog_counter
   import ctr_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   os_state_t        state_q, state_d;

   logic             is_sat;
   logic             is_oneshot;
   logic             is_wrap;
   logic             step_ok;
   logic             at_term_now;
   logic             at_term_step;
   logic [WIDTH-1:0] step_val;

   // Up terminal is "at or beyond limit" so a load above limit behaves as
   // terminal; down terminal is zero.
   function automatic logic at_term(input logic [WIDTH-1:0] value,
                                    input logic [WIDTH-1:0] lim,
                                    input logic             up);
      return up ? (value >= lim) : (value == '0);
   endfunction

   // Next-state: reset is handled in the register block, then load, then step.
   always_comb begin
      count_d      = count_q;
      tc_d         = 1'b0;
      busy_d       = busy_q;
      done_d       = done_q;
      state_d      = state_q;

      is_sat       = (mode == MODE_SAT);
      is_oneshot   = (mode == MODE_ONESHOT);
      is_wrap      = !is_sat && !is_oneshot;
      at_term_now  = at_term(count_q, limit, up_dn);

      // At terminal only wrap moves; saturate and one-shot hold.
      step_val     = count_q;
      if (!at_term_now)
         step_val = up_dn ? (count_q + 1'b1) : (count_q - 1'b1);
      else if (is_wrap)
         step_val = up_dn ? '0 : limit;
      at_term_step = at_term(step_val, limit, up_dn);

      // In one-shot mode only a started run may count.
      step_ok      = enable && (!is_oneshot || (state_q == OS_RUN));

      // Outside one-shot the handshake is parked, so re-entering starts idle.
      if (!is_oneshot) begin
         state_d = OS_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end

      if (load) begin
         count_d = load_val;
         if (is_oneshot) begin
            state_d = OS_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
         end
      end else if (step_ok) begin
         count_d = step_val;
         // A held terminal count is not a new arrival; wrap always re-arrives
         // (including limit=0 where 0 steps to 0).
         tc_d    = at_term_step && (is_wrap || !at_term_now);
         // A run loaded directly at terminal also completes on its first
         // enabled step, just without a tc pulse, so it cannot stall in RUN.
         if (is_oneshot && at_term_step) begin
            state_d = OS_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= RESET_COUNT;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         state_q <= OS_IDLE;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         state_q <= state_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, loadable up/down counter with a run-time programmable terminal value and three overflow modes: wrap, saturate and one-shot.
- Successor to the fixed 12-bit loadable counter. Used as the general timer/event-count primitive in the lab designs: dividers, timeouts and pulse-width generation.
- Provides a registered terminal-count pulse, and a busy/done handshake in one-shot mode.

Parameters:
WIDTH, 12, counter and data width in bits (>=2)
RESET_VAL, 0, value loaded into count on reset (must be <= 2**WIDTH-1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; highest priority
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value captured on load
enable  in  1  count-step qualifier
up_dn  in  1  1 = count up, 0 = count down
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
limit  in  WIDTH  terminal value for up-counting; sampled every cycle
count  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered)
busy  out  1  one-shot run in progress (registered)
done  out  1  one-shot complete, sticky until next load/reset (registered)

Behaviour:
- Clocking: clk and reset are fixed as above. Reset is synchronous, active-high, on clk; nothing is asynchronous (load is synchronous).
- Reset values: count=RESET_VAL, tc=0, busy=0, done=0, FSM=IDLE.
- Priority per cycle: reset > load > enable step > hold.
- Terminal: up terminal is count >= limit (unsigned); down terminal is count == 0.
- Load:
  - count <= load_val unclamped; tc <= 0.
  - In one-shot mode, FSM goes to RUN, busy <= 1, done <= 0.
  - If load_val > limit while counting up, the next enabled step is treated as a step from terminal.
- Step (enable=1, no load):
  - Not at terminal: count +/- 1 per up_dn.
  - At terminal, wrap: up -> 0; down -> limit.
  - At terminal, saturate: hold.
  - At terminal, one-shot: hold.
- tc:
  - Asserts for exactly one cycle, in the same cycle count first shows the terminal value as the result of an enabled step.
  - Not asserted after load or reset, even if the loaded value is terminal.
  - In saturate/one-shot, a held count does not re-pulse tc.
  - In wrap, tc re-pulses on each new arrival.
- One-shot FSM (mode=10): IDLE, RUN, DONE.
  - IDLE: no counting; enable ignored; load -> RUN.
  - RUN: counts while enabled. The step that arrives at terminal -> DONE, with busy <= 0, done <= 1 and tc pulsed in the same cycle.
  - DONE: count holds; load -> RUN.
  - Load while in RUN restarts from load_val.
- Mode and direction changes:
  - A mode change takes effect on the next edge.
  - Leaving one-shot forces FSM to IDLE, busy=0, done=0.
  - Entering one-shot starts in IDLE; a load is required to start counting.
  - An up_dn change mid-run is legal; the terminal test uses the current up_dn.
- limit=0: up and down terminal coincide at 0.
  - Wrap: count stays 0 and tc pulses on every enabled step.
  - Saturate/one-shot: a single arrival is required, so no pulse from 0 without a prior nonzero count.
- Arithmetic: WIDTH-bit unsigned with no carry out; down from 0 is only reached via the terminal rules above.
- Latency: count, tc, busy and done all update 1 cycle after the inputs are sampled.

Decomposition:
- Shared package ctr_pkg holds:
  - mode encodings MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10;
  - one-shot state typedef (IDLE, RUN, DONE).
- Single module. No sub-module is warranted; terminal detection is kept inline as a function.

Test Plan:
- Reset, WIDTH=12, limit=5, wrap, up, enable=1 for 8 cycles -> count 1,2,3,4,5,0,1,2; tc=1 only when count=5.
- Wrap, down, load 2 then enable -> count 2,1,0,5,4; tc high on the cycle count=0 is reached by step only.
- Saturate, up, limit=3, load 1, enable 5 cycles -> 2,3,3,3,3; tc single pulse at first 3.
- One-shot, limit=4:
  - enable before load -> count stays RESET_VAL, busy=0.
  - load 0, enable -> busy=1, count 1..4, done=1, busy=0 and tc pulse together at 4; count holds.
  - load 2 -> busy=1, done=0.
- Priority: reset and load both asserted with enable=1 -> count=RESET_VAL. load=1 with enable=1, load_val=7 -> count=7, tc=0.
- Mode switch one-shot->wrap while busy -> next cycle busy=0, done=0, counting continues. WIDTH=4, limit=15, up -> 14,15,0 with tc at 15.
